// File: rtl/fft_iter_frame_sequencer_pkg.sv
// Shared encodings for the iterative FFT frame sequencer: FSM states, RAM owner codes
// and the state-to-owner mapping used to drive the RAM port mux.
package fft_iter_frame_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_UNLOAD  = 3'd5;

    typedef enum logic [1:0] {
        SEL_LOAD = 2'd0,
        SEL_BUT  = 2'd1,
        SEL_UNLD = 2'd2
    } ram_sel_e;

    function automatic ram_sel_e sel_for_state(input logic [2:0] st);
        ram_sel_e sel;
        case (st)
            S_START, S_COMPUTE, S_DRAIN: sel = SEL_BUT;
            S_UNLOAD:                    sel = SEL_UNLD;
            default:                     sel = SEL_LOAD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fft_bit_reverse.sv
// Combinational bit-order reversal of an address; shared by the sample loader and the
// butterfly address generator.
module fft_bit_reverse #(
    parameter int WL = 5
) (
    input  logic [WL-1:0] addr,
    output logic [WL-1:0] rev
);

    // Mirror bit i onto bit WL-1-i
    always_comb begin
        for (int i = 0; i < WL; i++) begin
            rev[i] = addr[WL-1-i];
        end
    end

endmodule

// File: rtl/fft_iter_frame_sequencer.sv
// Frame scheduler for the iterative FFT core: hands the shared sample RAM to the loader,
// the butterfly engine and the unloader in turn, and starts/monitors the control unit.
module fft_iter_frame_sequencer
    import fft_iter_frame_sequencer_pkg::*;
#(
    parameter int LAYERS        = 5,
    parameter int BUTTERFLYES   = 16,
    parameter int LayWL         = 3,
    parameter int ButtWL        = 4,
    parameter int BUT_CLK_CYCLE = 5,
    parameter int DRAIN_CYC     = BUT_CLK_CYCLE,
    parameter int BITREV_IN     = 1,
    localparam int AddrWL       = ButtWL + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [AddrWL-1:0] IN_ADDR,
    output logic              CU_START,
    input  logic              CU_LAY_EN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [AddrWL-1:0] OUT_ADDR,
    output logic              OUT_LAST,
    output logic [1:0]        RAM_SEL,
    output logic              BUSY,
    output logic              DONE
);

    localparam int N       = 2 * BUTTERFLYES;
    localparam int DrainWL = $clog2(DRAIN_CYC + 1);
    localparam logic [AddrWL-1:0]  LAST_ADDR  = AddrWL'(N - 1);
    localparam logic [LayWL-1:0]   LAST_LAYER = LayWL'(LAYERS - 1);
    localparam logic [DrainWL-1:0] DRAIN_LOAD = DrainWL'(DRAIN_CYC - 1);

    logic [2:0]         state_r, state_s;
    logic [AddrWL-1:0]  in_cnt_r, in_cnt_s;
    logic [AddrWL-1:0]  out_cnt_r, out_cnt_s;
    logic [LayWL-1:0]   lay_cnt_r, lay_cnt_s;
    logic [DrainWL-1:0] drain_cnt_r, drain_cnt_s;
    logic               cu_start_r, cu_start_s;
    logic               done_r, done_s;
    logic               busy_r;
    logic               out_last_r;
    ram_sel_e           ram_sel_r;
    logic [AddrWL-1:0]  in_rev_s;

    fft_bit_reverse #(.WL(AddrWL)) u_in_rev (
        .addr (in_cnt_r),
        .rev  (in_rev_s)
    );

    assign IN_READY  = (state_r == S_LOAD) & EN;
    assign OUT_VALID = (state_r == S_UNLOAD) & EN;
    assign IN_ADDR   = (BITREV_IN != 0) ? in_rev_s : in_cnt_r;
    assign OUT_ADDR  = out_cnt_r;
    assign OUT_LAST  = out_last_r;
    assign CU_START  = cu_start_r;
    assign RAM_SEL   = ram_sel_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

    // Next-state and counter update; everything freezes while EN is low, pulses never stretch
    always_comb begin
        state_s     = state_r;
        in_cnt_s    = in_cnt_r;
        out_cnt_s   = out_cnt_r;
        lay_cnt_s   = lay_cnt_r;
        drain_cnt_s = drain_cnt_r;
        cu_start_s  = 1'b0;
        done_s      = 1'b0;
        if (EN) begin
            case (state_r)
                S_IDLE: state_s = S_LOAD;
                S_LOAD: begin
                    if (IN_VALID) begin
                        if (in_cnt_r == LAST_ADDR) begin
                            state_s    = S_START;
                            in_cnt_s   = AddrWL'(0);
                            cu_start_s = 1'b1;
                        end else begin
                            in_cnt_s = in_cnt_r + AddrWL'(1);
                        end
                    end else begin
                        in_cnt_s = in_cnt_r;
                    end
                end
                S_START: begin
                    // The start pulse must be seen in an enabled cycle; if EN dropped under it, reissue
                    if (cu_start_r) begin
                        state_s   = S_COMPUTE;
                        lay_cnt_s = LayWL'(0);
                    end else begin
                        cu_start_s = 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (CU_LAY_EN) begin
                        if (lay_cnt_r == LAST_LAYER) begin
                            state_s     = S_DRAIN;
                            lay_cnt_s   = LayWL'(0);
                            drain_cnt_s = DRAIN_LOAD;
                        end else begin
                            lay_cnt_s = lay_cnt_r + LayWL'(1);
                        end
                    end else begin
                        lay_cnt_s = lay_cnt_r;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == DrainWL'(0)) begin
                        state_s   = S_UNLOAD;
                        out_cnt_s = AddrWL'(0);
                    end else begin
                        drain_cnt_s = drain_cnt_r - DrainWL'(1);
                    end
                end
                S_UNLOAD: begin
                    if (OUT_READY) begin
                        if (out_cnt_r == LAST_ADDR) begin
                            state_s   = S_IDLE;
                            out_cnt_s = AddrWL'(0);
                            done_s    = 1'b1;
                        end else begin
                            out_cnt_s = out_cnt_r + AddrWL'(1);
                        end
                    end else begin
                        out_cnt_s = out_cnt_r;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs; RAM owner changes on the same edge as the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= S_IDLE;
            in_cnt_r    <= AddrWL'(0);
            out_cnt_r   <= AddrWL'(0);
            lay_cnt_r   <= LayWL'(0);
            drain_cnt_r <= DrainWL'(0);
            cu_start_r  <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            out_last_r  <= 1'b0;
            ram_sel_r   <= SEL_LOAD;
        end else begin
            state_r     <= state_s;
            in_cnt_r    <= in_cnt_s;
            out_cnt_r   <= out_cnt_s;
            lay_cnt_r   <= lay_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            cu_start_r  <= cu_start_s;
            done_r      <= done_s;
            busy_r      <= (state_s != S_IDLE);
            out_last_r  <= (state_s == S_UNLOAD) && (out_cnt_s == LAST_ADDR);
            ram_sel_r   <= sel_for_state(state_s);
        end
    end

endmodule

// File: tb/tb_fft_iter_frame_sequencer.sv
// Scoreboard bench for fft_iter_frame_sequencer: stimulus queues expected load/unload
// addresses, a negedge monitor pops and compares them on every handshake.
module tb_fft_iter_frame_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic       IN_VALID;
    logic       IN_READY;
    logic [4:0] IN_ADDR;
    logic       CU_START;
    logic       CU_LAY_EN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [4:0] OUT_ADDR;
    logic       OUT_LAST;
    logic [1:0] RAM_SEL;
    logic       BUSY;
    logic       DONE;

    int n_tests = 0;
    int n_fail  = 0;
    int cu_start_cnt = 0;
    int done_cnt = 0;
    int in_q[$];
    int out_q[$];

    // 5-bit bit-reversed load order, worked out by hand
    int brev_tab [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                          1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    fft_iter_frame_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_ADDR   (IN_ADDR),
        .CU_START  (CU_START),
        .CU_LAY_EN (CU_LAY_EN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_LAST  (OUT_LAST),
        .RAM_SEL   (RAM_SEL),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({IN_READY, IN_ADDR, CU_START, OUT_VALID, OUT_ADDR, OUT_LAST, RAM_SEL, BUSY, DONE});
    endfunction

    // Monitor: compare every handshake (and every stalled request) against the queues
    always @(negedge CLK) begin
        if (!RST) begin
            if (IN_VALID && IN_READY) begin
                if (in_q.size() == 0) check("in_unexpected", 1, 0);
                else check("in_addr", int'(IN_ADDR), in_q.pop_front());
            end
            if (OUT_VALID) begin
                if (out_q.size() == 0) check("out_unexpected", 1, 0);
                else if (OUT_READY) check("out_addr_last", int'({OUT_ADDR, OUT_LAST}), out_q.pop_front());
                else check("out_stall_hold", int'({OUT_ADDR, OUT_LAST}), out_q[0]);
            end
            if (CU_START) cu_start_cnt++;
            if (DONE) done_cnt++;
        end
    end

    task automatic run_frame(input int pause_at, input int abort_at);
        int c;
        @(posedge CLK); #1;
        cu_start_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 32; i++) in_q.push_back(brev_tab[i]);
        IN_VALID = 1'b1;
        if (pause_at >= 0) begin
            c = 0;
            while (in_q.size() > 32 - pause_at && c < 200) begin
                @(posedge CLK); #1; c++;
            end
            check("pause_reached", in_q.size(), 32 - pause_at);
            EN = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                check("pause_in_ready", IN_READY, 0);
                check("pause_in_addr", int'(IN_ADDR), brev_tab[pause_at]);
            end
            @(posedge CLK); #1 EN = 1'b1;
        end
        c = 0;
        while (in_q.size() != 0 && c < 200) begin
            @(posedge CLK); #1; c++;
        end
        check("load_done", in_q.size(), 0);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("start_pulse", CU_START, 1);
        check("start_in_ready", IN_READY, 0);
        check("start_ram_sel", RAM_SEL, 1);
        @(negedge CLK);
        check("start_single", CU_START, 0);
        for (int p = 1; p <= 5; p++) begin
            repeat (79) @(negedge CLK);
            check("compute_no_valid", OUT_VALID, 0);
            check("compute_ram_sel", RAM_SEL, 1);
            CU_LAY_EN = 1'b1;
            @(negedge CLK);
            CU_LAY_EN = 1'b0;
            if (p == abort_at) begin
                #2 RST = 1'b1;
                #1 check("abort_outputs", all_outs(), 0);
                @(negedge CLK);
                RST = 1'b0;
                return;
            end
        end
        for (int i = 0; i < 32; i++) out_q.push_back((i << 1) | ((i == 31) ? 1 : 0));
        // Stray layer pulse in the middle of the drain must not shorten or lengthen it
        for (int d = 0; d < 5; d++) begin
            if (d > 0) @(negedge CLK);
            check("drain_no_valid", OUT_VALID, 0);
            check("drain_ram_sel", RAM_SEL, 1);
            CU_LAY_EN = (d == 2);
        end
        @(negedge CLK);
        CU_LAY_EN = 1'b0;
        check("unload_valid", OUT_VALID, 1);
        check("unload_ram_sel", RAM_SEL, 2);
        check("unload_first_addr", int'(OUT_ADDR), 0);
        @(posedge CLK); #1 OUT_READY = 1'b1;
        c = 0;
        while (out_q.size() != 0 && c < 300) begin
            @(posedge CLK); #1; c++;
            if (out_q.size() != 0) OUT_READY = ~OUT_READY;
        end
        check("unload_done", out_q.size(), 0);
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("done_pulse", DONE, 1);
        check("done_busy", BUSY, 0);
        check("done_no_valid", OUT_VALID, 0);
        check("done_ram_sel", RAM_SEL, 0);
        @(negedge CLK);
        check("done_single", DONE, 0);
        check("cu_start_count", cu_start_cnt, 1);
        check("done_count", done_cnt, 1);
    endtask

    initial begin
        RST = 1'b1;
        EN = 1'b0;
        IN_VALID = 1'b0;
        CU_LAY_EN = 1'b0;
        OUT_READY = 1'b0;
        #3;
        check("reset_outputs", all_outs(), 0);
        @(negedge CLK);
        RST = 1'b0;
        EN = 1'b1;
        @(negedge CLK);
        check("load_in_ready", IN_READY, 1);
        check("load_busy", BUSY, 1);
        check("load_addr0", int'(IN_ADDR), 0);
        check("load_ram_sel", RAM_SEL, 0);
        run_frame(-1, 0);
        run_frame(11, 0);
        run_frame(-1, 2);
        run_frame(-1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
